lfsr_decrypt: RTL and testbench
===============================

LFSR_DECRYPT -- requirements
Module: lfsr_decrypt

Interface
REQ-001 Parameters SHALL be: DW, default 8, memory data width; AW, default 8, memory address width.
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 init  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to begin decryption; sampled only in IDLE.
REQ-005 raddr  out  AW  dat_mem read address; data_out is combinational from raddr in the same cycle.
REQ-006 data_out  in  DW  dat_mem read data.
REQ-007 write_en  out  1  dat_mem write strobe; data is written at the clk edge.
REQ-008 waddr  out  AW  dat_mem write address.
REQ-009 data_in  out  DW  dat_mem write data.
REQ-010 done  out  1  operation complete; held until the next accepted start.
REQ-011 found  out  1  valid with done; 1 means a tap candidate matched, 0 means failure.
REQ-012 taps_found  out  6  matched tap pattern; valid when done && found.

Function
REQ-013 The ciphertext SHALL occupy dat_mem[64..127], with byte k at 64+k, encrypted as plain ^ {2'b00, lfsr}.
REQ-014 The LFSR step SHALL be next = {s[4:0], ^(s & taps)}.
REQ-015 The FSM SHALL have states IDLE, SEED, TRY, RELOAD, RUN, DONE, FAIL.
REQ-016 IDLE -> SEED SHALL occur on start; all outputs are 0 in IDLE.
REQ-017 SEED (1 cycle) SHALL read address 64, set seed = data_out[5:0] ^ 6'h1F, set candidate index t = 0, and load the LFSR with seed.
REQ-018 TRY SHALL perform one compare per cycle for i = 0..6: read 64+i and compare (data_out[5:0] ^ lfsr) against 6'h1F.
  - Match: advance the LFSR.
  - Match at i = 6: latch taps_found and go to RELOAD.
  - Mismatch: t++, reload the LFSR with seed, restart at i = 0 in the same state.
  - Mismatch with t = 5: go to FAIL.
REQ-019 The candidate tap table SHALL be, in order: 6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39; the lowest-index match wins.
REQ-020 RELOAD (1 cycle) SHALL reload the LFSR with seed, clear k and j, and set in_pre = 1.
REQ-021 RUN SHALL process one byte per cycle for k = 0..63: read 64+k, compute plain = data_out ^ {2'b00, lfsr}, and advance the LFSR.
  - k < 7: never write.
  - k >= 7 with in_pre set and plain == 8'h5F: no write.
  - Otherwise: clear in_pre, write plain to waddr = j, then j++.
REQ-022 After k = 63 the FSM SHALL enter DONE with done = 1 and found = 1.
REQ-023 FAIL SHALL set done = 1 and found = 0, and SHALL never have written memory.
REQ-024 In DONE or FAIL, a new start SHALL restart from SEED, clearing done and found on the accepting edge.
REQ-025 start SHALL be ignored in all states except IDLE, DONE and FAIL.
REQ-026 If all of bytes 7..63 decrypt to 8'h5F, there SHALL be zero writes and the block SHALL still reach DONE with found = 1.
REQ-027 Counters k and j SHALL be 6 bits; j never exceeds 57, so no wrap is possible.
REQ-028 Worst-case latency from start to done SHALL be 1 + 6*7 + 1 + 64 = 108 cycles (correct tap at t = 5 and all compares before it fail late).
REQ-029 write_en SHALL be asserted only in RUN and SHALL be registered-state decoded, with no glitch on state transitions.

Reset
REQ-030 While init is high, the state SHALL be IDLE; done, found, write_en, taps_found, k, j, t, and the LFSR SHALL all be 0; this takes effect immediately, independent of clk.
REQ-031 Reset mid-RUN SHALL abort with no further writes; a subsequent start SHALL rerun from SEED.

Structure
REQ-032 Package lfsr_pkg SHALL hold:
  - the tap table (6 x 6-bit);
  - PRE_CHAR = 8'h5F, PRE_MASK6 = 6'h1F;
  - CT_BASE = 64, PRE_MIN = 7, MSG_BYTES = 64;
  - the FSM state enum.
REQ-033 One sub-module, lfsr6_ld, SHALL hold the 6-bit LFSR with inputs load, load_val, taps and adv (load has priority over adv) and output state.

Verification
REQ-034 Scenario: encrypt "Hello" with taps 6'h21, start 6'h01, preamble 10 -> found = 1, taps_found = 6'h21, mem[0..4] = "Hello", done within 108 cycles.
REQ-035 Scenario: same message with taps 6'h39 -> five candidate rejections, taps_found = 6'h39, identical plaintext.
REQ-036 Scenario: mem[64..127] filled with random bytes that match no candidate -> FAIL with done = 1, found = 0, and zero write_en pulses.
REQ-037 Scenario: preamble 7, first message char 0x5F-equivalent position check (message begins "A_B") -> mem[0..2] = "A_B", confirming an embedded '_' is kept.
REQ-038 Scenario: assert init at RUN k = 20 -> no writes after reset; restart yields correct output.
REQ-039 Scenario: start pulsed during TRY and during RUN -> ignored; the result is identical to the uninterrupted run.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants, candidate tap table and FSM encoding for the LFSR decryptor.
package lfsr_pkg;

    localparam int N_TAPS    = 6;
    localparam int CT_BASE   = 64;
    localparam int PRE_MIN   = 7;
    localparam int MSG_BYTES = 64;
    localparam int TRY_LEN   = 7;

    localparam logic [7:0] PRE_CHAR  = 8'h5F;
    localparam logic [5:0] PRE_MASK6 = 6'h1F;

    // Candidates are tried in this order; the first one that matches wins.
    localparam logic [5:0] TAP_TABLE [N_TAPS] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        TRY,
        RELOAD,
        RUN,
        DONE,
        FAIL
    } state_t;

endpackage

// File: rtl/lfsr6_ld.sv
// 6-bit Fibonacci-style LFSR with parallel load; load takes priority over advance.
module lfsr6_ld (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic [5:0] taps,
    input  logic       adv,
    output logic [5:0] state
);

    logic [5:0] state_q;
    logic [5:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (adv) begin
            state_d = {state_q[4:0], ^(state_q & taps)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_decrypt.sv
// Recovers the LFSR seed and taps from a known '_' preamble, then decrypts the
// 64-byte ciphertext at CT_BASE into memory starting at address 0, preamble stripped.
module lfsr_decrypt
    import lfsr_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          init,
    input  logic          start,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] data_out,
    output logic          write_en,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] data_in,
    output logic          done,
    output logic          found,
    output logic [5:0]    taps_found
);

    state_t     state_q, state_d;
    logic [2:0] t_q, t_d;
    logic [2:0] i_q, i_d;
    logic [5:0] k_q, k_d;
    logic [5:0] j_q, j_d;
    logic [5:0] seed_q, seed_d;
    logic [5:0] taps_found_q, taps_found_d;
    logic       in_pre_q, in_pre_d;

    logic [5:0]    lfsr;
    logic [5:0]    cur_taps;
    logic [5:0]    lfsr_ld_val;
    logic          lfsr_ld;
    logic          lfsr_adv;
    logic          rd_en;
    logic [5:0]    rd_off;
    logic          we;
    logic [DW-1:0] plain;
    logic          pre_match;

    assign cur_taps  = TAP_TABLE[t_q];
    assign plain     = data_out ^ DW'(lfsr);
    assign pre_match = (data_out[5:0] ^ lfsr) == PRE_MASK6;

    lfsr6_ld u_lfsr (
        .clk      (clk),
        .rst      (init),
        .load     (lfsr_ld),
        .load_val (lfsr_ld_val),
        .taps     (cur_taps),
        .adv      (lfsr_adv),
        .state    (lfsr)
    );

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        i_d          = i_q;
        k_d          = k_q;
        j_d          = j_q;
        seed_d       = seed_q;
        taps_found_d = taps_found_q;
        in_pre_d     = in_pre_q;
        lfsr_ld      = 1'b0;
        lfsr_ld_val  = seed_q;
        lfsr_adv     = 1'b0;
        rd_en        = 1'b0;
        rd_off       = '0;
        we           = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = SEED;
            end
            SEED: begin
                rd_en        = 1'b1;
                seed_d       = data_out[5:0] ^ PRE_MASK6;
                lfsr_ld      = 1'b1;
                lfsr_ld_val  = data_out[5:0] ^ PRE_MASK6;
                t_d          = '0;
                i_d          = '0;
                taps_found_d = '0;
                state_d      = TRY;
            end
            TRY: begin
                rd_en  = 1'b1;
                rd_off = {3'b000, i_q};
                if (pre_match) begin
                    lfsr_adv = 1'b1;
                    if (i_q == 3'(TRY_LEN - 1)) begin
                        taps_found_d = cur_taps;
                        state_d      = RELOAD;
                    end else begin
                        i_d = i_q + 3'd1;
                    end
                end else begin
                    // Candidate rejected: rewind to the seed and try the next taps.
                    lfsr_ld = 1'b1;
                    i_d     = '0;
                    if (t_q == 3'(N_TAPS - 1)) begin
                        state_d = FAIL;
                    end else begin
                        t_d = t_q + 3'd1;
                    end
                end
            end
            RELOAD: begin
                lfsr_ld  = 1'b1;
                k_d      = '0;
                j_d      = '0;
                in_pre_d = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                rd_en    = 1'b1;
                rd_off   = k_q;
                lfsr_adv = 1'b1;
                // Only the leading run of '_' after the minimum preamble is dropped.
                if (k_q >= 6'(PRE_MIN) && !(in_pre_q && plain == DW'(PRE_CHAR))) begin
                    in_pre_d = 1'b0;
                    we       = 1'b1;
                    j_d      = j_q + 6'd1;
                end
                if (k_q == 6'(MSG_BYTES - 1)) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 6'd1;
                end
            end
            DONE, FAIL: begin
                if (start) state_d = SEED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q      <= IDLE;
            t_q          <= '0;
            i_q          <= '0;
            k_q          <= '0;
            j_q          <= '0;
            seed_q       <= '0;
            taps_found_q <= '0;
            in_pre_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            i_q          <= i_d;
            k_q          <= k_d;
            j_q          <= j_d;
            seed_q       <= seed_d;
            taps_found_q <= taps_found_d;
            in_pre_q     <= in_pre_d;
        end
    end

    assign raddr      = rd_en ? (AW'(CT_BASE) + AW'(rd_off)) : '0;
    assign write_en   = we;
    assign waddr      = we ? AW'(j_q) : '0;
    assign data_in    = we ? plain : '0;
    assign done       = (state_q == DONE) || (state_q == FAIL);
    assign found      = (state_q == DONE);
    assign taps_found = taps_found_q;

endmodule

// File: tb/tb_lfsr_decrypt.sv
// Bench for lfsr_decrypt: memory model, vector table, corner sequences and random trials.
module tb_lfsr_decrypt;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          init = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] raddr;
    logic [DW-1:0] data_out;
    logic          write_en;
    logic [AW-1:0] waddr;
    logic [DW-1:0] data_in;
    logic          done;
    logic          found;
    logic [5:0]    taps_found;

    logic [7:0]  mem [0:255];
    logic [7:0]  pt [0:63];
    logic [15:0] exp_q [$];
    logic [15:0] sb_e;
    logic [5:0]  cand [0:5] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;

    typedef struct {
        logic [5:0]  tp;
        logic [5:0]  st;
        int          pre;
        logic [63:0] msg;
        int          mlen;
        bit          pad5f;
        bit          e_found;
        logic [5:0]  e_taps;
        int          e_cycles;
        int          e_writes;
    } vec_t;

    vec_t vecs [4];

    // ---------------- clock / reset / memory ----------------
    always #5 clk = ~clk;

    lfsr_decrypt #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .init       (init),
        .start      (start),
        .raddr      (raddr),
        .data_out   (data_out),
        .write_en   (write_en),
        .waddr      (waddr),
        .data_in    (data_in),
        .done       (done),
        .found      (found),
        .taps_found (taps_found)
    );

    assign data_out = mem[raddr];

    always @(posedge clk) begin
        if (write_en) mem[waddr] = data_in;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (write_en) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: waddr=%0d data=%0h, required no write", waddr, data_in);
            end else begin
                sb_e = exp_q.pop_front();
                check("write_addr_data", {16'h0, waddr, data_in}, {16'h0, sb_e});
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [5:0] step(input logic [5:0] s, input logic [5:0] tp);
        return {s[4:0], ^(s & tp)};
    endfunction

    task automatic build_ct(input logic [5:0] tp, input logic [5:0] st, input int pre,
                            input logic [63:0] msg, input int mlen, input bit pad5f);
        logic [5:0] s;
        s = st;
        for (int k = 0; k < 64; k++) begin
            if (k < pre) pt[k] = 8'h5F;
            else if (k < pre + mlen) pt[k] = msg[8*(mlen-1-(k-pre)) +: 8];
            else pt[k] = pad5f ? 8'h5F : 8'($urandom_range(0, 255));
            mem[64+k] = pt[k] ^ {2'b00, s};
            s = step(s, tp);
        end
        for (int a = 0; a < 64; a++) mem[a] = 8'h00;
    endtask

    // Search candidates in table order, then the expected writes are the decrypted
    // bytes from index 7 onward with the leading '_' run removed.
    task automatic model(output bit m_found, output logic [5:0] m_taps, output int m_ntry);
        logic [7:0] dec [0:63];
        logic [5:0] seed, s;
        bit         ok;
        int         first;
        seed    = mem[64][5:0] ^ 6'h1F;
        m_found = 1'b0;
        m_taps  = '0;
        m_ntry  = 0;
        for (int t = 0; t < 6 && !m_found; t++) begin
            s  = seed;
            ok = 1'b1;
            for (int i = 0; i < 7 && ok; i++) begin
                m_ntry++;
                if ((mem[64+i][5:0] ^ s) != 6'h1F) ok = 1'b0;
                s = step(s, cand[t]);
            end
            if (ok) begin
                m_found = 1'b1;
                m_taps  = cand[t];
            end
        end
        exp_q.delete();
        if (m_found) begin
            s = seed;
            for (int k = 0; k < 64; k++) begin
                dec[k] = mem[64+k] ^ {2'b00, s};
                s = step(s, m_taps);
            end
            first = 7;
            while (first < 64 && dec[first] == 8'h5F) first++;
            for (int k = first; k < 64; k++) exp_q.push_back({8'(k - first), dec[k]});
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_case(input int p1, input int p2, output int cycles);
        int cnt;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_clear_on_start", {30'h0, done, found}, 32'h0);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 300) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (done) seen = 1'b1;
            start = !done && (cnt == p1 || cnt == p2);
        end
        start = 1'b0;
        check("done_reached", {31'h0, seen}, 32'h1);
        cycles = cnt;
    endtask

    // ---------------- test ----------------
    initial begin
        bit         m_found;
        logic [5:0] m_taps;
        int         m_ntry;
        int         cyc;
        logic [5:0] sd;

        vecs[0] = '{6'h21, 6'h01, 10, 64'h48656C6C6F, 5, 1'b0, 1'b1, 6'h21, 73, 54};
        vecs[1] = '{6'h39, 6'h01, 10, 64'h48656C6C6F, 5, 1'b0, 1'b1, 6'h39, 89, 54};
        vecs[2] = '{6'h21, 6'h01, 7,  64'h415F42,     3, 1'b0, 1'b1, 6'h21, 73, 57};
        vecs[3] = '{6'h21, 6'h01, 7,  64'h0,          0, 1'b1, 1'b1, 6'h21, 73, 0};

        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        init  = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done_found", {30'h0, done, found}, 32'h0);
        check("rst_write_en", {31'h0, write_en}, 32'h0);
        check("rst_taps_found", {26'h0, taps_found}, 32'h0);
        check("rst_addr_data", {8'h0, raddr, waddr, data_in}, 32'h0);
        init = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", {write_en, done, found, 5'h0, raddr, waddr, data_in}, 32'h0);

        // Table vectors: nominal taps, late taps, embedded '_', all-preamble message.
        for (int v = 0; v < 4; v++) begin
            build_ct(vecs[v].tp, vecs[v].st, vecs[v].pre, vecs[v].msg, vecs[v].mlen, vecs[v].pad5f);
            model(m_found, m_taps, m_ntry);
            n_writes = 0;
            run_case(0, 0, cyc);
            check($sformatf("v%0d_found", v), {31'h0, found}, {31'h0, vecs[v].e_found});
            check($sformatf("v%0d_taps", v), {26'h0, taps_found}, {26'h0, vecs[v].e_taps});
            check($sformatf("v%0d_cycles", v), cyc, vecs[v].e_cycles);
            check($sformatf("v%0d_writes", v), n_writes, vecs[v].e_writes);
            check($sformatf("v%0d_sb_drained", v), exp_q.size(), 0);
            for (int b = 0; b < vecs[v].mlen; b++)
                check($sformatf("v%0d_mem%0d", v, b), {24'h0, mem[b]},
                      {24'h0, vecs[v].msg[8*(vecs[v].mlen-1-b) +: 8]});
        end

        // Random ciphertext that no candidate can match: fail with no writes.
        for (int a = 0; a < 64; a++) mem[64+a] = 8'($urandom_range(0, 255));
        for (int a = 0; a < 64; a++) mem[a] = 8'h00;
        sd = mem[64][5:0] ^ 6'h1F;
        mem[65] = {mem[65][7:6], {~sd[4:0], 1'b0} ^ 6'h1F};
        model(m_found, m_taps, m_ntry);
        n_writes = 0;
        run_case(0, 0, cyc);
        check("fail_done", {31'h0, done}, 32'h1);
        check("fail_found", {31'h0, found}, 32'h0);
        check("fail_cycles", cyc, 13);
        check("fail_no_writes", n_writes, 0);

        // Reset asserted in RUN at k = 20, then a clean rerun.
        build_ct(6'h21, 6'h01, 10, 64'h48656C6C6F, 5, 1'b0);
        model(m_found, m_taps, m_ntry);
        while (exp_q.size() > 10) void'(exp_q.pop_back());
        n_writes = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1 init = 1'b1;
        @(negedge clk);
        check("abort_outputs", {write_en, done, found, 5'h0, raddr, waddr, data_in}, 32'h0);
        check("abort_taps_found", {26'h0, taps_found}, 32'h0);
        repeat (3) @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        check("abort_writes", n_writes, 10);
        check("abort_sb_drained", exp_q.size(), 0);
        check("abort_last_written", {24'h0, mem[9]}, {24'h0, pt[19]});
        check("abort_not_written", {24'h0, mem[10]}, 32'h0);
        model(m_found, m_taps, m_ntry);
        run_case(0, 0, cyc);
        check("rerun_found", {31'h0, found}, 32'h1);
        check("rerun_cycles", cyc, 73);
        check("rerun_sb_drained", exp_q.size(), 0);
        check("rerun_mem_hello", {mem[0], mem[1], mem[2], mem[3]}, 32'h48656C6C);

        // Start pulses during TRY and RUN must not disturb the run.
        build_ct(6'h39, 6'h01, 10, 64'h48656C6C6F, 5, 1'b0);
        model(m_found, m_taps, m_ntry);
        run_case(5, 50, cyc);
        check("pulse_cycles", cyc, 89);
        check("pulse_taps", {26'h0, taps_found}, 32'h39);
        check("pulse_sb_drained", exp_q.size(), 0);
        check("pulse_mem_hello", {mem[1], mem[2], mem[3], mem[4]}, 32'h656C6C6F);

        // Random trials against the model.
        for (int r = 0; r < 8; r++) begin
            build_ct(cand[$urandom_range(0, 5)], 6'($urandom_range(1, 63)), $urandom_range(7, 12),
                     {$urandom, $urandom}, $urandom_range(1, 8), 1'b0);
            model(m_found, m_taps, m_ntry);
            run_case(0, 0, cyc);
            check($sformatf("rnd%0d_found", r), {31'h0, found}, {31'h0, m_found});
            if (m_found) check($sformatf("rnd%0d_taps", r), {26'h0, taps_found}, {26'h0, m_taps});
            check($sformatf("rnd%0d_cycles", r), cyc, m_found ? (66 + m_ntry) : (1 + m_ntry));
            check($sformatf("rnd%0d_latency_bound", r), {31'h0, cyc <= 108}, 32'h1);
            check($sformatf("rnd%0d_sb_drained", r), exp_q.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
